// File: rtl/abs_share_if.sv
// Handshake bundle between the operand sources, the shared abs arbiter and the result consumer.
// The slave modport is the arbiter side; the master modport is the source/consumer side.
interface abs_share_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic [ID_W-1:0]      out_id;
    logic                 out_ovf;

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_id,
        output out_ovf
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_id,
        input  out_ovf
    );
endinterface

// File: rtl/abs_share_arbiter.sv
// Round-robin shared 8-bit absolute-value unit with a one-entry, id-tagged result register.
// Build option ABS_SAT_EN: operand 8'h80 saturates to 8'h7F instead of wrapping to 8'h80.
module abs_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    abs_share_if.slave  bus
);
    localparam int                DATA_W  = 8;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]     NUM_EXT = (ID_W+1)'(NUM_REQ);

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] a);
        logic [DATA_W-1:0] u;
        u       = a;
        abs_mag = a[DATA_W-1] ? (~u + DATA_W'(1)) : u;
`ifdef ABS_SAT_EN
        if (u == MIN_NEG) abs_mag = MAX_POS;
`else
        if (u == MIN_NEG) abs_mag = MIN_NEG;
`endif
    endfunction

    state_t                   r_state;
    logic [ID_W-1:0]          r_rr_ptr;
    logic [DATA_W-1:0]        r_mag_p1;
    logic [ID_W-1:0]          r_id_p1;
    logic                     r_ovf_p1;

    logic                     w_found;
    logic [ID_W-1:0]          w_gnt;
    logic [ID_W:0]            w_sum;
    logic [ID_W-1:0]          w_idx;
    logic signed [DATA_W-1:0] w_opnd;
    logic                     w_can_acc;
    logic                     w_acc;
    logic [NUM_REQ-1:0]       w_onehot;

    // Walk downward from the farthest offset so the nearest request at or after rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= NUM_EXT) w_sum = w_sum - NUM_EXT;
            w_idx = w_sum[ID_W-1:0];
            if (bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    always_comb begin
        w_opnd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == ID_W'(i)) w_opnd = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Grants are suppressed while reset is asserted, independent of the register state.
    assign w_can_acc = (r_state == ST_EMPTY) | bus.out_ready;
    assign w_acc     = rst_n & w_can_acc & w_found;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_onehot[i] = w_acc & (w_gnt == ID_W'(i));
        end
    end

    // Stage p1: registered result, tag and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_rr_ptr <= '0;
            r_mag_p1 <= '0;
            r_id_p1  <= '0;
            r_ovf_p1 <= 1'b0;
        end else begin
            if (w_acc) begin
                r_mag_p1 <= abs_mag(w_opnd);
                r_id_p1  <= w_gnt;
                r_ovf_p1 <= ($unsigned(w_opnd) == MIN_NEG);
                r_rr_ptr <= (w_gnt == LAST_ID) ? '0 : (w_gnt + ID_W'(1));
            end
            case (r_state)
                ST_EMPTY: if (w_acc) r_state <= ST_FULL;
                ST_FULL:  if (bus.out_ready && !w_acc) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.req_ready = w_onehot;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.out_data  = r_mag_p1;
    assign bus.out_id    = r_id_p1;
    assign bus.out_ovf   = r_ovf_p1;

endmodule

// File: tb/tb_abs_share_arbiter.sv
// Self-checking bench for abs_share_arbiter: directed cases plus randomized traffic against a queue-free reference model.
module tb_abs_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    abs_share_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    abs_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference: magnitude via integer arithmetic on the signed value, truncated to 8 bits.
    function automatic int ref_abs(input logic [7:0] d);
        int v;
        v = (d >= 8'd128) ? int'(d) - 256 : int'(d);
        if (v < 0) v = -v;
`ifdef ABS_SAT_EN
        if (v > 127) v = 127;
`endif
        return v & 255;
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    int m_ptr, m_id, m_data;
    bit m_valid, m_ovf;

    always @(posedge clk or negedge rst_n) begin : model
        int g;
        logic [7:0] d;
        if (!rst_n) begin
            m_ptr = 0; m_id = 0; m_data = 0; m_valid = 0; m_ovf = 0;
        end else begin
            g = pick(bus.req_valid, m_ptr);
            if (g >= 0 && (!m_valid || bus.out_ready)) begin
                d       = bus.req_data[g*8 +: 8];
                m_data  = ref_abs(d);
                m_ovf   = (d == 8'h80);
                m_id    = g;
                m_valid = 1;
                m_ptr   = (g + 1) % NUM_REQ;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        int exp_rdy;
        if (!rst_n) begin
            chk("rst_req_ready", int'(bus.req_ready), 0);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_out_data",  int'(bus.out_data), 0);
            chk("rst_out_id",    int'(bus.out_id), 0);
            chk("rst_out_ovf",   int'(bus.out_ovf), 0);
        end else begin
            g = pick(bus.req_valid, m_ptr);
            exp_rdy = (g >= 0 && (!m_valid || bus.out_ready)) ? (1 << g) : 0;
            chk("req_ready", int'(bus.req_ready), exp_rdy);
            chk("out_valid", int'(bus.out_valid), int'(m_valid));
            chk("out_data",  int'(bus.out_data), m_data);
            chk("out_id",    int'(bus.out_id), m_id);
            chk("out_ovf",   int'(bus.out_ovf), int'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        bus.req_data = {d3, d2, d1, d0};
    endtask

    initial begin
        int ids [5];
        int mags[5];
        int h_data, h_id, h_ovf;
        logic [7:0] d [NUM_REQ];
        int exp_80;
        ids  = '{0, 1, 2, 3, 0};
        mags = '{8'h01, 8'h01, 8'h7F, 8'h7F, 8'h01};
`ifdef ABS_SAT_EN
        exp_80 = 8'h7F;
`else
        exp_80 = 8'h80;
`endif
        n_tests = 0;
        n_fail  = 0;

        // Reset held with every requester asking.
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (3) step();
        chk("t1_req_ready", int'(bus.req_ready), 0);
        chk("t1_out_valid", int'(bus.out_valid), 0);
        chk("t1_out_data",  int'(bus.out_data), 0);

        // Single requester.
        bus.req_valid = 4'b0100;
        set_data(8'h00, 8'h00, 8'hF6, 8'h00);
        #2 rst_n = 1'b1;
        step();
        chk("t2_out_data",  int'(bus.out_data), 8'h0A);
        chk("t2_out_id",    int'(bus.out_id), 2);
        chk("t2_out_ovf",   int'(bus.out_ovf), 0);
        chk("t2_out_valid", int'(bus.out_valid), 1);

        // Round-robin over all four.
        bus.req_valid = 4'b1111;
        set_data(8'h01, 8'hFF, 8'h7F, 8'h81);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_out_id",   int'(bus.out_id), ids[i]);
            chk("t3_out_data", int'(bus.out_data), mags[i]);
        end

        // Backpressure, then drain and refill on one edge.
        bus.out_ready = 1'b0;
        #1;
        chk("t4_req_ready_hold", int'(bus.req_ready), 0);
        h_data = bus.out_data; h_id = bus.out_id; h_ovf = bus.out_ovf;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_data",  int'(bus.out_data), h_data);
            chk("t4_hold_id",    int'(bus.out_id), h_id);
            chk("t4_hold_ovf",   int'(bus.out_ovf), h_ovf);
            chk("t4_hold_valid", int'(bus.out_valid), 1);
            chk("t4_hold_ready", int'(bus.req_ready), 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4_release_ready", int'(bus.req_ready), 4'b0010);
        step();
        chk("t4_refill_valid", int'(bus.out_valid), 1);
        chk("t4_refill_id",    int'(bus.out_id), 1);
        chk("t4_refill_data",  int'(bus.out_data), 8'h01);

        // Most-negative operand and zero.
        bus.req_valid = 4'b0001;
        set_data(8'h80, 8'h00, 8'h00, 8'h00);
        do_reset();
        step();
        chk("t5_min_data", int'(bus.out_data), exp_80);
        chk("t5_min_ovf",  int'(bus.out_ovf), 1);
        set_data(8'h00, 8'h00, 8'h00, 8'h00);
        step();
        chk("t5_zero_data", int'(bus.out_data), 8'h00);
        chk("t5_zero_ovf",  int'(bus.out_ovf), 0);

        // Asynchronous reset while a result is held.
        bus.out_ready = 1'b0;
        step();
        chk("t6_full_before", int'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid_drop", int'(bus.out_valid), 0);
        chk("t6_ready_rst",  int'(bus.req_ready), 0);
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b1;
        step();
        chk("t6_first_id",    int'(bus.out_id), 1);
        chk("t6_first_valid", int'(bus.out_valid), 1);

        // Randomized traffic, including dropped requests and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            bus.req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                case ($urandom_range(0, 7))
                    0:       d[i] = 8'h80;
                    1:       d[i] = 8'h00;
                    default: d[i] = 8'($urandom);
                endcase
            end
            set_data(d[0], d[1], d[2], d[3]);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
